// File: rtl/present_pkg.sv
// Shared PRESENT-80 constants, S-box table and the key-schedule update rule.
package present_pkg;

  localparam int KEY_W = 80;
  localparam int RK_W  = 64;
  localparam int RC_W  = 6;

  // Nibble i of this constant is S(i); entry 0 sits in the low nibble.
  localparam logic [63:0] PRESENT_SBOX = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
    return PRESENT_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[KEY_W-1:19]};
    r[79:76]   = sbox_lookup(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box, purely combinational; also used by the cipher sBoxLayer.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] sbox_in,
  output logic [3:0] sbox_out
);

  assign sbox_out = sbox_lookup(sbox_in);

endmodule

// File: rtl/gen_round_keys.sv
// PRESENT-80 key schedule: loads the master key, then advances one round per
// enabled edge; the current round key is the top 64 bits of the key register.
module gen_round_keys
  import present_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  key,
  input  logic              enable_in,
  input  logic [RC_W-1:0]   round_counter,
  output logic [RK_W-1:0]   round_out
);

  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] key_rot;
  logic [KEY_W-1:0] key_next;
  logic [3:0]       sbox_out;
  logic             rc_msb_unused;

  // Counter wraps mod 32, so its top bit never reaches the datapath.
  assign rc_msb_unused = round_counter[RC_W-1];

  // Rotate left by 61 == rotate right by 19.
  assign key_rot = {key_reg[18:0], key_reg[KEY_W-1:19]};

  present_sbox u_sbox (
    .sbox_in  (key_rot[79:76]),
    .sbox_out (sbox_out)
  );

  assign key_next = {sbox_out,
                     key_rot[75:20],
                     key_rot[19:15] ^ round_counter[4:0],
                     key_rot[14:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_reg <= '0;
    end else if (enable_in) begin
      key_reg <= key_next;
    end else begin
      key_reg <= key;
    end
  end

  assign round_out = key_reg[KEY_W-1:KEY_W-RK_W];

endmodule

// File: tb/tb_gen_round_keys.sv
// Self-checking bench for gen_round_keys against a plain-arithmetic PRESENT-80 key model.
module tb_gen_round_keys;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [79:0] key;
  logic        enable_in;
  logic [5:0]  round_counter;
  logic [63:0] round_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [79:0] m_key;
  int sbox_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  gen_round_keys dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key           (key),
    .enable_in     (enable_in),
    .round_counter (round_counter),
    .round_out     (round_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference round: rotate by shifting, S-box from the table, counter added mod 32.
  function automatic logic [79:0] ref_update(input logic [79:0] k, input int rc);
    logic [79:0] r;
    int          top;
    int          mix;
    r   = (k << 61) | (k >> 19);
    top = sbox_tab[int'(r[79:76])];
    r[79:76] = 4'(top);
    mix = int'(r[19:15]) ^ (rc % 32);
    r[19:15] = 5'(mix);
    return r;
  endfunction

  function automatic logic [63:0] ref_rk(input logic [79:0] k);
    return k[79:16];
  endfunction

  // One clock: apply inputs, advance the model, then sample #1 after the edge.
  task automatic step(input logic en, input logic [79:0] k, input logic [5:0] rc);
    enable_in     = en;
    key           = k;
    round_counter = rc;
    @(posedge clock);
    #1;
    if (en) m_key = ref_update(m_key, int'(rc));
    else    m_key = k;
  endtask

  initial begin
    reset_n       = 1'b0;
    key           = '0;
    enable_in     = 1'b0;
    round_counter = '0;
    m_key         = '0;
    #12;
    chk("reset_state", round_out, 64'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Load all-zero key and the two published first rounds.
    step(1'b0, 80'h0, 6'd0);
    chk("load_zero", round_out, 64'h0);
    step(1'b1, 80'h0, 6'd1);
    chk("round1", round_out, 64'hC000000000000000);
    step(1'b1, 80'h0, 6'd2);
    chk("round2", round_out, 64'h5000180000000001);

    // Full schedule from zero key.
    step(1'b0, 80'h0, 6'd0);
    for (int i = 1; i <= 31; i++) begin
      step(1'b1, 80'h0, 6'(i));
      chk($sformatf("sched_k%0d", i + 1), round_out, ref_rk(m_key));
    end
    chk("k32_const", round_out, 64'h6DAB31744F41D700);

    // Counter bit 5 must be ignored.
    step(1'b0, 80'h0, 6'd0);
    step(1'b1, 80'h0, 6'h21);
    chk("rc_bit5", round_out, 64'hC000000000000000);

    // Hold, updates with a changing key input, then reload.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, {80{1'b1}}, 6'(i));
      chk($sformatf("hold_ff_%0d", i), round_out, 64'hFFFFFFFFFFFFFFFF);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {$urandom, $urandom, 16'($urandom)}, 6'($urandom_range(0, 63)));
      chk($sformatf("ff_upd_%0d", i), round_out, ref_rk(m_key));
    end
    step(1'b0, {80{1'b1}}, 6'd7);
    chk("reload_ff", round_out, 64'hFFFFFFFFFFFFFFFF);

    // Counter 0: rotation plus S-box only.
    step(1'b1, 80'h0, 6'd0);
    chk("rc_zero", round_out, ref_rk(m_key));

    // Randomized mix of loads and updates.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 7) != 0), {$urandom, $urandom, 16'($urandom)},
           6'($urandom_range(0, 63)));
      chk($sformatf("rand_%0d", i), round_out, ref_rk(m_key));
    end

    // Asynchronous reset mid-sequence, no clock edge needed.
    reset_n = 1'b0;
    m_key   = '0;
    #1;
    chk("async_reset", round_out, 64'h0);
    #2;
    reset_n = 1'b1;
    step(1'b1, 80'h0, 6'd1);
    chk("post_reset_upd", round_out, 64'hC000000000000000);
    step(1'b0, 80'h0123456789ABCDEF0123, 6'd3);
    chk("post_reset_load", round_out, 64'h0123456789ABCDEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
